// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the simple CPU subsystem.
//   - FSM state encodings (IDLE..DONE, 3-bit)
//   - opcode constants
//   - data word width
//   - instruction field bit positions
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_DEC        = 3'd2,
    S_LOAD_OP    = 3'd3,
    S_LOAD_WAIT  = 3'd4,
    S_EXEC       = 3'd5,
    S_WRITE_BACK = 3'd6,
    S_DONE       = 3'd7
  } cpu_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_NOT = 1'b1;

  localparam int unsigned WORD_WIDTH = 8;

  // Instruction layout: [9:7] res, [6:4] op2, [3:1] op1, [0] opCode
  localparam int unsigned OPC_POS     = 0;
  localparam int unsigned OP1_LSB     = 1;
  localparam int unsigned OP2_LSB     = 4;
  localparam int unsigned RES_LSB     = 7;
  localparam int unsigned FIELD_WIDTH = 3;

endpackage

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: control FSM of the simple CPU. Runs instructions 0..MEM_DEPTH-1
// once per start, six cycles each (FETCH..WRITE_BACK), then holds DONE.
// Optional trace: define CPU_TRACE_EN to print every write-back.
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   start                  run request, honoured only in IDLE/DONE
//   done                   high while in DONE
//   instr_addr/instr_data  instruction memory read port
//   rd_addr_a/rd_data_a    data memory operand 1 read port
//   rd_addr_b/rd_data_b    data memory operand 2 read port
//   wr_en/wr_addr/wr_data  data memory write port
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned MEM_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [WORD_WIDTH-1:0] rd_data_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [WORD_WIDTH-1:0] rd_data_b,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(MEM_DEPTH - 1);

  cpu_state_t            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  opCode;
  logic [ADDR_WIDTH-1:0] op1;
  logic [ADDR_WIDTH-1:0] op2;
  logic [ADDR_WIDTH-1:0] res;
  logic [WORD_WIDTH-1:0] result;
  logic [WORD_WIDTH-1:0] opa;
  logic [WORD_WIDTH-1:0] opb;

  // Memory addresses are driven straight from registers; the memories
  // register the read, so data appears one state later.
  assign instr_addr = pc;
  assign rd_addr_a  = op1;
  assign rd_addr_b  = op2;
  // Write strobe is decoded from state so an asynchronous reset during
  // WRITE_BACK removes it before the edge that would commit it.
  assign wr_en      = (state == S_WRITE_BACK);
  assign wr_addr    = res;
  assign wr_data    = result;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      pc     <= '0;
      opCode <= OP_ADD;
      op1    <= '0;
      op2    <= '0;
      res    <= '0;
      result <= '0;
      opa    <= '0;
      opb    <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DEC;
        S_DEC: begin
          opCode <= instr_data[OPC_POS];
          op1    <= instr_data[OP1_LSB +: ADDR_WIDTH];
          op2    <= instr_data[OP2_LSB +: ADDR_WIDTH];
          res    <= instr_data[RES_LSB +: ADDR_WIDTH];
          state  <= S_LOAD_OP;
        end
        S_LOAD_OP: state <= S_LOAD_WAIT;
        S_LOAD_WAIT: begin
          opa   <= rd_data_a;
          opb   <= rd_data_b;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result <= (opCode == OP_NOT) ? ~opa : (opa + opb);
          state  <= S_WRITE_BACK;
        end
        S_WRITE_BACK: begin
          if (pc == LAST_PC) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            pc    <= pc + ADDR_WIDTH'(1);
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          if (start) begin
            pc    <= '0;
            done  <= 1'b0;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CPU_TRACE_EN
  always_ff @(posedge clk) begin
    if (rstn && state == S_WRITE_BACK) begin
      $display("%0t pc=%0d %s op1=%0d op2=%0d res=%0d result=%0d",
               $time, pc, (opCode == OP_NOT) ? "NOT" : "ADD",
               op1, op2, res, result);
    end
  end
`else
`endif

endmodule

// File: rtl/cpu_mem.sv
// cpu_mem: parameterised memory with two synchronous read ports
// (1-cycle latency) and one synchronous write port. Contents are not
// reset, so they persist across runs and across reset.
// Ports:
//   clk                    clock
//   rd_addr_a / rd_data_a  read port A (address in, registered data out)
//   rd_addr_b / rd_data_b  read port B (address in, registered data out)
//   wr_en, wr_addr, wr_data  write port
module cpu_mem #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [WIDTH-1:0]      rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [WIDTH-1:0]      rd_data_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_a <= mem[rd_addr_a];
    rd_data_b <= mem[rd_addr_b];
  end

endmodule

// File: rtl/simple_cpu_top.sv
// simple_cpu_top: two-opcode memory-to-memory CPU subsystem. Control FSM
// plus an instruction memory and a 2R1W data memory. Instance names
// uut_cpu, uut_instr_mem and uut_data_mem are relied upon hierarchically.
// Optional trace: define CPU_TRACE_EN (handled inside uut_cpu).
// Ports:
//   clk    clock
//   rstn   asynchronous active-low reset
//   start  begins a run when the CPU is idle or done
//   done   high while the program has completed
module simple_cpu_top
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned MEM_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic done
);

  logic [ADDR_WIDTH-1:0] instr_addr;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [DATA_WIDTH-1:0] instr_port_b_unused;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [WORD_WIDTH-1:0] rd_data_a;
  logic [WORD_WIDTH-1:0] rd_data_b;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;

  cpu_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) uut_cpu (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .done       (done),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  // Instruction memory is read-only at run time; port B and the write
  // port are tied off.
  cpu_mem #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) uut_instr_mem (
    .clk       (clk),
    .rd_addr_a (instr_addr),
    .rd_data_a (instr_data),
    .rd_addr_b ('0),
    .rd_data_b (instr_port_b_unused),
    .wr_en     (1'b0),
    .wr_addr   ('0),
    .wr_data   ('0)
  );

  cpu_mem #(
    .WIDTH      (WORD_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) uut_data_mem (
    .clk       (clk),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

endmodule

// File: tb/tb_simple_cpu_top.sv
// tb_simple_cpu_top: directed self-checking bench for simple_cpu_top.
module tb_simple_cpu_top;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic start = 1'b0;
  logic done;

  int checks   = 0;
  int failures = 0;
  int lat;

  logic [9:0] instr_tab [8];
  logic [7:0] data_tab  [8];
  logic [7:0] exp_tab   [8];

  simple_cpu_top #(
    .DATA_WIDTH (10),
    .MEM_DEPTH  (8),
    .ADDR_WIDTH (3)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 8; i++) begin
      dut.uut_instr_mem.mem[i] = instr_tab[i];
      dut.uut_data_mem.mem[i]  = data_tab[i];
    end
  endtask

  task automatic check_data(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_d%0d", tag, i), dut.uut_data_mem.mem[i], exp_tab[i]);
    end
  endtask

  // Pulse start (sampled at edge N), then count edges until done rises.
  // Optionally injects start pulses that land in EXEC and WRITE_BACK.
  task automatic run(input bit inject, output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_low_after_start", done, 0);
    cycles = 0;
    while (!done && cycles < 200) begin
      start = inject && (cycles == 10 || cycles == 17);
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
  endtask

  initial begin
    // Reference program and data
    instr_tab = '{10'h110, 10'h194, 10'h205, 10'h2C6, 10'h30B, 10'h380, 10'h3FE, 10'h000};
    data_tab  = '{8'd5, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    load_mem();
    #1;
    check("reset_done",   done, 0);
    check("reset_state",  dut.uut_cpu.state, 0);
    check("reset_pc",     dut.uut_cpu.pc, 0);
    check("reset_result", dut.uut_cpu.result, 0);
    check("reset_res",    dut.uut_cpu.res, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Pass 1
    run(1'b0, lat);
    check("latency_pass1", lat, 48);
    exp_tab = '{8'd10, 8'd3, 8'd8, 8'd11, 8'd247, 8'd2, 8'd253, 8'd20};
    check_data("pass1");
    repeat (3) @(posedge clk);
    #1;
    check("done_held", done, 1);

    // Pass 2 from pass-1 contents, with stray start pulses mid-run
    run(1'b1, lat);
    check("latency_pass2", lat, 48);
    exp_tab = '{8'd20, 8'd3, 8'd13, 8'd16, 8'd242, 8'd2, 8'd253, 8'd40};
    check_data("pass2");

    // Wrap-around: 200+100 -> 44, ~0 -> 255; remaining ops write 0+0 to d7
    instr_tab = '{10'h110, 10'h189, 10'h3EA, 10'h3EA, 10'h3EA, 10'h3EA, 10'h3EA, 10'h3EA};
    data_tab  = '{8'd200, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9};
    load_mem();
    run(1'b0, lat);
    check("latency_wrap", lat, 48);
    exp_tab = '{8'd200, 8'd100, 8'd44, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
    check_data("wrap");

    // Reset mid-run during instruction 3 (EXEC), before its write-back
    instr_tab = '{10'h110, 10'h194, 10'h205, 10'h2C6, 10'h30B, 10'h380, 10'h3FE, 10'h000};
    data_tab  = '{8'd5, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    load_mem();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (22) @(posedge clk);
    #2;
    check("pre_reset_pc", dut.uut_cpu.pc, 3);
    rstn = 1'b0;
    #1;
    check("async_reset_state", dut.uut_cpu.state, 0);
    check("async_reset_pc",    dut.uut_cpu.pc, 0);
    check("async_reset_done",  done, 0);
    // Memory written while in reset must survive release
    dut.uut_data_mem.mem[6] = 8'd77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_tab = '{8'd5, 8'd3, 8'd8, 8'd11, 8'd247, 8'd0, 8'd77, 8'd0};
    check_data("midreset");
    check("post_reset_state", dut.uut_cpu.state, 0);
    check("post_reset_done",  done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_cpu_top.md
# simple_cpu_top

Self-contained two-opcode accumulator-free CPU: a control FSM plus an 8-entry instruction memory and an 8-entry, 8-bit data memory. On a `start` pulse it executes instructions 0 through `MEM_DEPTH-1` once, in order. Each instruction is a memory-to-memory ADD or NOT. It then raises `done`. It is the top of the CPU subsystem, and benches load both memories hierarchically before starting it.

## Interface
- `DATA_WIDTH`, default 10: instruction word width.
- `MEM_DEPTH`, default 8: entries in each memory; also the program length.
- `ADDR_WIDTH`, default 3: address and operand field width; `MEM_DEPTH = 2**ADDR_WIDTH`.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  level, sampled in IDLE or DONE; begins a run.
- `done`  out  1  high while in DONE; reset value 0.

## Operation
- Instruction format: [9:7] `res` (destination address), [6:4] `op2`, [3:1] `op1`, [0] `opCode`.
- `opCode` values: 0 = ADD, 1 = NOT.
- Data words are 8 bits wide. ADD computes `data[op1] + data[op2]` modulo 256, with carry discarded. NOT computes `~data[op1]`, and `op2` is ignored.
- Result is written to `data[res]`. Destination may equal a source; the write uses values read before it.
- FSM, 3-bit encoding:
  - IDLE=0: `start`=1 sets pc to 0 and moves to FETCH.
  - FETCH=1: present pc to the instruction memory.
  - DEC=2: latch the instruction; split it into `opCode`, `op1`, `op2`, `res`.
  - LOAD_OP=3: present `op1` and `op2` to the data memory read ports.
  - LOAD_WAIT=4: capture both operands.
  - EXEC=5: register `result`.
  - WRITE_BACK=6: write `result` to `data[res]`. If pc = `MEM_DEPTH-1`, go to DONE. Otherwise increment pc and go to FETCH.
  - DONE=7: `done`=1. `start`=1 here restarts the run at pc 0.
- `start` is ignored in states 1–6.
- Memories are not cleared by reset; their contents persist across runs and across reset.
- Reset asserted mid-run returns to IDLE immediately. Any in-flight write is dropped. Writes already completed remain.

## Timing
- Both memories use synchronous read with 1-cycle latency and synchronous write.
- Data memory has two read ports and one write port.
- Each instruction takes exactly 6 cycles (FETCH through WRITE_BACK).
- A `start` sampled in IDLE at edge N puts the FSM in FETCH after edge N. `done` rises 48 cycles later for `MEM_DEPTH`=8, that is 6 × `MEM_DEPTH` cycles.
- A write in WRITE_BACK is visible to the next instruction's LOAD_OP; no forwarding is needed.
- Reset values: state=IDLE, pc=0, `opCode`/`op1`/`op2`/`res`=0, `result`=0, `done`=0.

## Configuration
- `CPU_TRACE_EN` defined: at every WRITE_BACK, simulation prints time, pc, mnemonic, `op1`, `op2`, `res` and `result` via `$display`.
- `CPU_TRACE_EN` undefined: no trace code is compiled. Functional behaviour and timing are identical with and without it.

## Structure
- Shared package `cpu_pkg` holds:
  - state encodings (IDLE..DONE);
  - opcode constants (`OP_ADD`=0, `OP_NOT`=1);
  - the 8-bit data word width;
  - instruction field bit positions.
- Instance names are fixed because benches access them hierarchically:
  - `uut_cpu`: control FSM, exposing regs `state`, `pc`, `opCode`, `op1`, `op2`, `res`, `result`;
  - `uut_instr_mem`: array `mem`, `DATA_WIDTH` bits × `MEM_DEPTH`;
  - `uut_data_mem`: array `mem`, 8 bits × `MEM_DEPTH`.
- A single parameterised memory sub-module `cpu_mem` (width/depth, 2R1W) is natural and serves both memory instances.

## Test plan
- Reference program:
  - data = {5,3,0,0,0,0,0,0};
  - instr = {0x110, 0x194, 0x205, 0x2C6, 0x30B, 0x380, 0x3FE, 0x000};
  - pulse `start` → `done`=1 and data = {10,3,8,11,247,2,253,20}.
- Latency: `start` sampled in IDLE → `done` rises exactly 48 cycles after FETCH entry; `done`=0 before that.
- Wrap: ADD 200+100 → 44; NOT 0 → 255.
- Reset mid-run: assert `rstn`=0 during instruction 3 → state IDLE, `done`=0, pc=0 asynchronously; data[2..4] hold 8, 11, 247 and data[5] is unchanged.
- Restart: after DONE, pulse `start` again with the same program → pass-2 values computed from pass-1 memory contents; `start` pulses during states 1–6 are ignored.
- Memory written while `rstn`=0 is retained after reset release.
